// File: rtl/chamber_drain_if.sv
// Command/status bundle between the airlock supervisor (master) and the
// chamber drain controller (slave).
interface chamber_drain_if #(
  parameter int LEVEL_W = 8
);
  logic               level_load;
  logic [LEVEL_W-1:0] level_in;
  logic               drain_req;
  logic               door_closed;
  logic               abort;
  logic               draining;
  logic               paused;
  logic               drained;
  logic               done_pulse;
  logic [LEVEL_W-1:0] water_level;

  modport master (
    output level_load, level_in, drain_req, door_closed, abort,
    input  draining, paused, drained, done_pulse, water_level
  );

  modport slave (
    input  level_load, level_in, drain_req, door_closed, abort,
    output draining, paused, drained, done_pulse, water_level
  );
endinterface

// File: rtl/chamber_drain_ctrl.sv
// Airlock chamber drain controller: holds the water level and, once started,
// lowers it by one unit every STEP_CYCLES clocks while the door interlock is
// closed. Every output comes straight from a register.
module chamber_drain_ctrl #(
  parameter int LEVEL_W     = 8,
  parameter int STEP_CYCLES = 50000000,
  parameter int RESET_LEVEL = 0
) (
  input  logic           clk,
  input  logic           reset,
  chamber_drain_if.slave bus
);

  localparam int CNT_W = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_RST = LEVEL_W'(RESET_LEVEL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAINING = 2'd1,
    PAUSED   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LEVEL_W-1:0] level_q, level_n;
  logic               done_n;

  logic draining_q, paused_q, drained_q, done_q;

  // Next-state, step counter and level decisions for the coming edge.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_n = state;
    cnt_n   = cnt;
    level_n = level_q;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        // A load in the same cycle as a request is honoured first, so the
        // start decision looks at the freshly loaded value.
        if (bus.level_load) begin
          level_n = bus.level_in;
        end
        if (bus.drain_req && bus.door_closed && (level_n != '0)) begin
          state_n = DRAINING;
          cnt_n   = '0;
        end
      end

      DRAINING, PAUSED: begin
        if (bus.abort) begin
          // Abort beats everything, including a final decrement.
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!bus.door_closed) begin
          // Door open: freeze count and level, no decrement this edge.
          state_n = PAUSED;
        end else begin
          // Door closed: count this edge. The resume edge out of PAUSED also
          // counts, so a pause of P cycles costs exactly P cycles.
          state_n = DRAINING;
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (level_q != '0) begin
              level_n = level_q - LEVEL_W'(1);
              if (level_q == LEVEL_W'(1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter, level and registered status outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      level_q    <= LEVEL_RST;
      draining_q <= 1'b0;
      paused_q   <= 1'b0;
      drained_q  <= (RESET_LEVEL == 0);
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      level_q    <= level_n;
      draining_q <= (state_n == DRAINING);
      paused_q   <= (state_n == PAUSED);
      drained_q  <= (level_n == '0);
      done_q     <= done_n;
    end
  end

  assign bus.draining    = draining_q;
  assign bus.paused      = paused_q;
  assign bus.drained     = drained_q;
  assign bus.done_pulse  = done_q;
  assign bus.water_level = level_q;

endmodule

// File: doc/chamber_drain_ctrl.md
# chamber_drain_ctrl

Sequential drain controller for the bathysphere airlock chamber. It holds the chamber water level and, on request, lowers it one unit every STEP_CYCLES clocks while the door interlock is closed. Its `draining` output drives the 1-bit input port of the Draining PIO, so software polls pump activity through the Avalon bus. It also reports the live level and a one-cycle completion pulse.

## Interface
- LEVEL_W, 8: width of the water level.
- STEP_CYCLES, 50000000: clocks per one-unit level decrement (1 s at 50 MHz); must be ≥ 2.
- RESET_LEVEL, 0: water level loaded on reset; must be < 2^LEVEL_W.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- level_load  in  1  pulse; load `level_in` into the level register (IDLE only).
- level_in  in  LEVEL_W  level value for `level_load`.
- drain_req  in  1  pulse; start draining (IDLE only).
- door_closed  in  1  interlock; draining progresses only while high.
- abort  in  1  pulse; stop draining, keep the current level.
- draining  out  1  pump active (state DRAINING); feeds the Draining PIO `in_port`.
- paused  out  1  state PAUSED.
- drained  out  1  `water_level == 0`.
- done_pulse  out  1  one-cycle pulse when the level reaches 0 by draining.
- water_level  out  LEVEL_W  current level.

## Operation
- States: IDLE, DRAINING, PAUSED. Internal step counter `cnt`, width ceil(log2(STEP_CYCLES)).
- All outputs are registered or decoded directly from registered state; there is no combinational input-to-output path.
- Reset (sampled at an edge):
  - state = IDLE, `cnt` = 0, `water_level` = RESET_LEVEL.
  - `draining` = `paused` = `done_pulse` = 0.
  - `drained` = (RESET_LEVEL == 0).
- Priority at every edge: reset > abort > all other events.
- IDLE:
  - `level_load` → `water_level` ← `level_in`.
  - `drain_req` with `door_closed` = 1 and `water_level` ≠ 0 → DRAINING, `cnt` ← 0.
  - `drain_req` with `water_level` = 0 or `door_closed` = 0 → ignored; no pulse, no state change.
  - `level_load` and `drain_req` in the same cycle → load takes effect; drain starts only if the loaded value ≠ 0 and `door_closed` = 1.
- DRAINING:
  - Each cycle: `cnt` increments.
  - At `cnt` = STEP_CYCLES-1: `cnt` ← 0 and `water_level` decrements by 1.
  - If that decrement makes the level 0: go to IDLE and set `done_pulse` = 1 for exactly one cycle.
  - `door_closed` = 0 → PAUSED; `cnt` holds. The door check wins over a decrement in the same cycle, so no decrement occurs.
- PAUSED:
  - `cnt` and `water_level` hold.
  - `door_closed` = 1 → DRAINING; counting resumes from the held `cnt`.
- `abort` in DRAINING or PAUSED → IDLE, `cnt` ← 0, level unchanged, no `done_pulse`. This applies even on the cycle a final decrement would have occurred.
- Ignored inputs:
  - `level_load` outside IDLE.
  - `drain_req` outside IDLE.
  - `abort` in IDLE.
- The level never underflows; no decrement happens at 0.

## Timing
- `drain_req` sampled at edge N → `draining` = 1 from after edge N.
- First decrement occurs at edge N+STEP_CYCLES.
- Level L with no pauses → level reaches 0 at edge N+L·STEP_CYCLES. At that same edge `draining` → 0, `drained` → 1 and `done_pulse` → 1; `done_pulse` clears at the next edge.
- A pause of P cycles in DRAINING extends completion by exactly P cycles.
- `level_load` at edge N → `water_level` and `drained` are valid after edge N.
- Reset asserted mid-drain → the reset values apply after that edge; no `done_pulse`.

## Test plan
All scenarios use STEP_CYCLES = 4.
- Reset with RESET_LEVEL = 0 → `water_level` = 0, `drained` = 1, all other outputs 0; `drain_req` → ignored, `draining` stays 0.
- Load 3, `drain_req` at edge 0 with door closed:
  - `draining` = 1 over edges 0–11.
  - Level reads 2, 1, 0 after edges 4, 8, 12.
  - `done_pulse` high only in the cycle after edge 12.
  - `draining` = 0 after edge 12.
- Load 2, drain, drop `door_closed` after 2 cycles for 5 cycles → `paused` = 1, `draining` = 0 while the door is open; completion slips from edge 8 to edge 13.
- Load 5, drain, `abort` at edge 6 → IDLE, level = 4, no `done_pulse`.
  - A new `drain_req` then needs 16 cycles to reach 0.
- During DRAINING, `level_load` = 9 and repeated `drain_req` → both ignored; timing unchanged.
  - Reset asserted at edge 5 → level = RESET_LEVEL and IDLE after that edge.
